pool2d_layer: RTL and testbench



---
 rtl/pool2d_layer.sv | 233 +++++++++++++++++++++++
 tb/tb_pool2d_layer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2d_layer.sv
// pool2d_layer: streaming KxK max / average / min pooling with independent stride and a registered output stage.
// Optional macro POOL2D_LAST_EN adds last_o, which flags the final pooled pixel of each frame.
module pool2d_layer #(
    parameter int LineWidthPx = 16,
    parameter int LineCountPx = 12,
    parameter int WidthIn     = 8,
    parameter int KernelWidth = 2,
    parameter int Stride      = KernelWidth,
    parameter int InChannels  = 1,
    parameter int PoolMode    = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [InChannels*WidthIn-1:0] data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
`ifdef POOL2D_LAST_EN
    output logic                          last_o,
`endif
    output logic [InChannels*WidthIn-1:0] data_o
);

    localparam int K    = KernelWidth;
    localparam int KK   = K * K;
    localparam int PixW = InChannels * WidthIn;
    localparam int KM1  = (K > 1) ? K - 1 : 1;
    localparam int XW   = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
    localparam int YW   = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;
    localparam int PhW  = (Stride > 1) ? $clog2(Stride) : 1;
    localparam int SumW = WidthIn + $clog2(KK) + 1;

    localparam logic [XW-1:0]  X_MAX   = XW'(LineWidthPx - 1);
    localparam logic [YW-1:0]  Y_MAX   = YW'(LineCountPx - 1);
    localparam logic [XW-1:0]  X_K     = XW'(K - 1);
    localparam logic [YW-1:0]  Y_K     = YW'(K - 1);
    localparam logic [PhW-1:0] PH_LAST = PhW'(Stride - 1);

    if (PoolMode < 0 || PoolMode > 2) begin : g_bad_mode
        $error("pool2d_layer: PoolMode must be 0 (max), 1 (average) or 2 (min)");
    end
    if (K < 1 || Stride < 1 || LineWidthPx < K || LineCountPx < K) begin : g_bad_geom
        $error("pool2d_layer: illegal kernel, stride or frame geometry");
    end

    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [PhW-1:0] px_q, px_d;
    logic [PhW-1:0] py_q, py_d;
    logic           valid_q, valid_d;
    logic [PixW-1:0] data_q, data_d;

    logic in_fire_s, eol_s, eof_s, win_ok_s, produce_s;
    logic [PixW-1:0]       win_s [K][K];
    logic [KK*WidthIn-1:0] chan_vals_s [InChannels];
    logic [PixW-1:0]       pool_s;

    assign ready_o   = ~valid_q | ready_i;
    assign in_fire_s = valid_i & ready_o;
    assign eol_s     = (x_q == X_MAX);
    assign eof_s     = eol_s & (y_q == Y_MAX);
    assign win_ok_s  = (x_q >= X_K) & (y_q >= Y_K) & (px_q == '0) & (py_q == '0);
    assign produce_s = in_fire_s & win_ok_s;

    // Reduce one channel's KxK window; max/min are unsigned, average rounds half up.
    function automatic logic [WidthIn-1:0] reduce_window(input logic [KK*WidthIn-1:0] vals);
        logic [WidthIn-1:0] ext;
        logic [SumW-1:0]    sum;
        ext = vals[WidthIn-1:0];
        sum = '0;
        for (int i = 0; i < KK; i++) begin
            if (PoolMode == 2) begin
                if (vals[i*WidthIn +: WidthIn] < ext) ext = vals[i*WidthIn +: WidthIn];
                else ext = ext;
            end else begin
                if (vals[i*WidthIn +: WidthIn] > ext) ext = vals[i*WidthIn +: WidthIn];
                else ext = ext;
            end
            sum = sum + SumW'(vals[i*WidthIn +: WidthIn]);
        end
        sum = sum + SumW'(KK / 2);
        if (PoolMode != 1) begin
            return ext;
        end else if ((KK & (KK - 1)) == 0) begin
            return WidthIn'(sum >> $clog2(KK));
        end else begin
            return WidthIn'(sum / SumW'(KK));
        end
    endfunction

    if (K > 1) begin : g_buf
        logic [PixW-1:0] lb_q  [KM1][LineWidthPx];
        logic [PixW-1:0] col_q [KM1][K];
        logic [PixW-1:0] cur_col_s [K];

        // Current column: live pixel on top of the same column from the previous K-1 rows.
        always_comb begin
            cur_col_s[0] = data_i;
            for (int r = 1; r < K; r++) begin
                cur_col_s[r] = lb_q[r-1][x_q];
            end
        end

        // Row delays and stored window columns advance only on accepted pixels.
        always_ff @(posedge clk_i) begin
            if (in_fire_s) begin
                lb_q[0][x_q] <= data_i;
                for (int r = 1; r < KM1; r++) begin
                    lb_q[r][x_q] <= lb_q[r-1][x_q];
                end
                col_q[0] <= cur_col_s;
                for (int c = 1; c < KM1; c++) begin
                    col_q[c] <= col_q[c-1];
                end
            end
        end

        // Window view: column 0 is the pixel being accepted, higher columns are older.
        always_comb begin
            for (int r = 0; r < K; r++) begin
                win_s[r][0] = cur_col_s[r];
                for (int c = 1; c < K; c++) begin
                    win_s[r][c] = col_q[c-1][r];
                end
            end
        end
    end else begin : g_nobuf
        // A 1x1 window is just the pixel being accepted.
        always_comb begin
            win_s[0][0] = data_i;
        end
    end

    // Gather each channel's window samples and reduce them.
    always_comb begin
        pool_s = '0;
        for (int ch = 0; ch < InChannels; ch++) begin
            chan_vals_s[ch] = '0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    chan_vals_s[ch][(r*K+c)*WidthIn +: WidthIn] = win_s[r][c][ch*WidthIn +: WidthIn];
                end
            end
            pool_s[ch*WidthIn +: WidthIn] = reduce_window(chan_vals_s[ch]);
        end
    end

    // Raster position and stride phases; phases only run once the window fits.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        px_d = px_q;
        py_d = py_q;
        if (in_fire_s) begin
            if (eol_s) begin
                x_d  = '0;
                px_d = '0;
                if (eof_s) begin
                    y_d  = '0;
                    py_d = '0;
                end else begin
                    y_d = y_q + 1'b1;
                    if (y_q >= Y_K) py_d = (py_q == PH_LAST) ? '0 : py_q + 1'b1;
                    else py_d = py_q;
                end
            end else begin
                x_d = x_q + 1'b1;
                if (x_q >= X_K) px_d = (px_q == PH_LAST) ? '0 : px_q + 1'b1;
                else px_d = px_q;
            end
        end else begin
            x_d = x_q;
        end
    end

`ifdef POOL2D_LAST_EN
    localparam logic [XW-1:0] X_LAST = XW'((K - 1) + Stride * ((LineWidthPx - K) / Stride));
    localparam logic [YW-1:0] Y_LAST = YW'((K - 1) + Stride * ((LineCountPx - K) / Stride));
    logic last_q, last_d;

    // Frame-final flag travels with the output pixel and holds under backpressure.
    always_comb begin
        last_d = last_q;
        if (ready_o) last_d = produce_s & (x_q == X_LAST) & (y_q == Y_LAST);
        else last_d = last_q;
    end

    // Frame-final flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= 1'b0;
        else last_q <= last_d;
    end

    assign last_o = last_q;
`endif

    // Output stage: refills whenever empty or being drained, otherwise holds.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = produce_s;
            if (produce_s) data_d = pool_s;
            else data_d = data_q;
        end else begin
            valid_d = valid_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q     <= '0;
            y_q     <= '0;
            px_q    <= '0;
            py_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            px_q    <= px_d;
            py_q    <= py_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_pool2d_layer.sv
// Bench for pool2d_layer: several geometries/modes in parallel, each checked every cycle against a frame-array model.
module tb_pool2d_layer;

    localparam int NCFG = 6;

    logic clk;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field f of configuration g: 0=width 1=height 2=K 3=stride 4=channels 5=mode.
    function automatic int cfg(input int g, input int f);
        logic [5:0][7:0] t;
        case (g)
            0:       t = {8'd0, 8'd1, 8'd2, 8'd2, 8'd4, 8'd4};
            1:       t = {8'd1, 8'd1, 8'd2, 8'd2, 8'd4, 8'd4};
            2:       t = {8'd2, 8'd1, 8'd2, 8'd2, 8'd4, 8'd4};
            3:       t = {8'd0, 8'd1, 8'd1, 8'd3, 8'd5, 8'd5};
            4:       t = {8'd0, 8'd1, 8'd3, 8'd2, 8'd7, 8'd7};
            default: t = {8'd1, 8'd2, 8'd2, 8'd3, 8'd5, 8'd6};
        endcase
        return int'(t[f]);
    endfunction

    // Hand-computed outputs of a ramp frame (pixel = y*W + x) for each configuration.
    function automatic int lit_n(input int g);
        if (g == 3) return 9;
        else return 4;
    endfunction

    function automatic int lit_v(input int g, input int i);
        logic [8:0][7:0] v;
        case (g)
            0:       v = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd15, 8'd13, 8'd7, 8'd5};
            1:       v = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd13, 8'd11, 8'd5, 8'd3};
            2:       v = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd8, 8'd2, 8'd0};
            3:       v = {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12};
            4:       v = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd32, 8'd29, 8'd11, 8'd8};
            default: v = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd21, 8'd19, 8'd9, 8'd7};
        endcase
        return int'(v[i]);
    endfunction

    task automatic check(input int g, input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got %0d expected %0d (t=%0t)", g, name, act, exp, $time);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_cfg
            localparam int W    = cfg(gi, 0);
            localparam int H    = cfg(gi, 1);
            localparam int K    = cfg(gi, 2);
            localparam int S    = cfg(gi, 3);
            localparam int CH   = cfg(gi, 4);
            localparam int MODE = cfg(gi, 5);
            localparam int KK   = K * K;
            localparam int PXW  = CH * 8;

            logic           rst_n, vin, rin, vout, rout;
            logic [PXW-1:0] din, dout;
`ifdef POOL2D_LAST_EN
            logic           lout;
`endif

            pool2d_layer #(
                .LineWidthPx(W), .LineCountPx(H), .WidthIn(8), .KernelWidth(K),
                .Stride(S), .InChannels(CH), .PoolMode(MODE)
            ) u_dut (
                .clk_i   (clk),
                .rst_ni  (rst_n),
                .valid_i (vin),
                .ready_o (rout),
                .data_i  (din),
                .valid_o (vout),
                .ready_i (rin),
`ifdef POOL2D_LAST_EN
                .last_o  (lout),
`endif
                .data_o  (dout)
            );

            logic [PXW-1:0] img [H][W];
            logic [PXW:0]   expq [$];
            logic [PXW-1:0] logq [$];
            int             mx = 0, my = 0, in_cnt = 0, rmode = 0;
            bit             logging = 1'b0;

            function automatic logic [PXW-1:0] rep(input int v);
                logic [7:0] b;
                b = 8'(v);
                return {CH{b}};
            endfunction

            // Pool the window whose bottom-right corner is (x, y) straight from the stored frame.
            function automatic logic [PXW-1:0] pool_ref(input int x, input int y);
                logic [PXW-1:0] res;
                int mxv, mnv, sum, v;
                res = '0;
                for (int ch = 0; ch < CH; ch++) begin
                    mxv = 0; mnv = 255; sum = 0;
                    for (int r = y - K + 1; r <= y; r++) begin
                        for (int c = x - K + 1; c <= x; c++) begin
                            v = int'(img[r][c][ch*8 +: 8]);
                            if (v > mxv) mxv = v;
                            if (v < mnv) mnv = v;
                            sum += v;
                        end
                    end
                    case (MODE)
                        0:       res[ch*8 +: 8] = 8'(mxv);
                        1:       res[ch*8 +: 8] = 8'((sum + KK / 2) / KK);
                        default: res[ch*8 +: 8] = 8'(mnv);
                    endcase
                end
                return res;
            endfunction

            // Model update and comparison on the falling edge, where inputs and outputs are settled.
            initial begin
                logic [PXW-1:0] res;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        expq.delete();
                        mx = 0;
                        my = 0;
                        check(gi, vout == 1'b0, "reset_valid_o", vout, 0);
                    end else begin
                        check(gi, vout == (expq.size() != 0), "valid_o", vout, expq.size() != 0);
                        check(gi, rout == (expq.size() == 0 || rin), "ready_o", rout, expq.size() == 0 || rin);
                        if (vout && expq.size() != 0) begin
                            check(gi, dout == expq[0][PXW-1:0], "data_o", dout, expq[0][PXW-1:0]);
`ifdef POOL2D_LAST_EN
                            check(gi, lout == expq[0][PXW], "last_o", lout, expq[0][PXW]);
`endif
                            if (rin) void'(expq.pop_front());
                        end
                        if (vin && rout) begin
                            img[my][mx] = din;
                            in_cnt++;
                            if (mx >= K - 1 && my >= K - 1 && (mx - K + 1) % S == 0 && (my - K + 1) % S == 0) begin
                                res = pool_ref(mx, my);
                                expq.push_back({(mx + S > W - 1) && (my + S > H - 1), res});
                                if (logging) logq.push_back(res);
                            end
                            mx++;
                            if (mx == W) begin
                                mx = 0;
                                my++;
                                if (my == H) my = 0;
                            end
                        end
                    end
                end
            end

            // Downstream ready: steady, random, or a single three-cycle stall once an output is waiting.
            initial begin
                int             snap;
                logic [PXW-1:0] held;
                rin = 1'b1;
                forever begin
                    @(posedge clk);
                    #1;
                    if (rmode == 1) begin
                        rin = 1'($urandom_range(0, 1));
                    end else if (rmode == 2 && vout) begin
                        rin  = 1'b0;
                        snap = in_cnt;
                        held = dout;
                        repeat (3) begin
                            @(negedge clk);
                            check(gi, rout == 1'b0, "stall_ready_o", rout, 0);
                            check(gi, vout == 1'b1 && dout == held, "stall_hold", dout, held);
                            @(posedge clk);
                            #1;
                        end
                        check(gi, in_cnt == snap, "stall_no_accept", in_cnt, snap);
                        rin   = 1'b1;
                        rmode = 0;
                    end else begin
                        rin = 1'b1;
                    end
                end
            end

            task automatic send(input logic [PXW-1:0] v);
                bit acc;
                int n;
                vin = 1'b1;
                din = v;
                acc = 1'b0;
                n   = 0;
                while (!acc && n < 200) begin
                    @(negedge clk);
                    acc = rout;
                    n++;
                    @(posedge clk);
                    #1;
                end
                check(gi, acc, "accept_timeout", acc, 1);
                vin = 1'b0;
            endtask

            task automatic drain();
                int n;
                n = 0;
                while (expq.size() != 0 && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check(gi, expq.size() == 0, "drain", expq.size(), 0);
            endtask

            // Stimulus sequence for this configuration.
            initial begin
                rst_n = 1'b0;
                vin   = 1'b0;
                din   = '0;
                repeat (3) @(posedge clk);
                #1;
                check(gi, vout == 1'b0, "rst_valid_o", vout, 0);
                check(gi, dout == '0, "rst_data_o", dout, 0);
                check(gi, rout == 1'b1, "rst_ready_o", rout, 1);
                rst_n = 1'b1;
                @(posedge clk);
                #1;

                // Ramp frame at full throughput, pinned against hand-computed values.
                logging = 1'b1;
                for (int p = 0; p < W * H; p++) send(rep(p));
                drain();
                logging = 1'b0;
                check(gi, logq.size() == lit_n(gi), "lit_count", logq.size(), lit_n(gi));
                for (int i = 0; i < logq.size() && i < lit_n(gi); i++) begin
                    for (int ch = 0; ch < CH; ch++) begin
                        check(gi, int'(logq[i][ch*8 +: 8]) == lit_v(gi, i), "lit_value",
                              logq[i][ch*8 +: 8], lit_v(gi, i));
                    end
                end

                // Random frame with one forced downstream stall.
                rmode = 2;
                for (int p = 0; p < W * H; p++) send(PXW'($urandom));
                drain();
                check(gi, rmode == 0, "stall_seen", rmode, 0);

                // Three random frames with input gaps and random ready.
                rmode = 1;
                for (int p = 0; p < 3 * W * H; p++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(PXW'($urandom));
                end
                drain();

                // Reset mid-row just after the first window of a frame, then a fresh frame.
                rmode = 0;
                for (int p = 0; p < (K - 1) * W + K; p++) send(PXW'($urandom));
                check(gi, vout == 1'b1, "pre_reset_valid_o", vout, 1);
                rst_n = 1'b0;
                #1;
                check(gi, vout == 1'b0, "async_reset_valid_o", vout, 0);
                check(gi, dout == '0, "async_reset_data_o", dout, 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                rmode = 1;
                for (int p = 0; p < W * H; p++) send(PXW'($urandom));
                drain();
                rmode = 0;
                n_done++;
            end
        end
    endgenerate

    // Wait for every configuration with a global bound, then report.
    initial begin
        for (int c = 0; c < 40000 && n_done < NCFG; c++) @(posedge clk);
        check(-1, n_done == NCFG, "global_timeout", n_done, NCFG);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
